// File: rtl/multiword_add_seq.sv
// ----------------------------------------------------------------------------
// multiword_add_seq
//
// Performs a wide (N*WORDS-bit) add or subtract with a single N-bit adder
// slice. The slice is reused over several cycles, least-significant word
// first, and the carry is chained from one slice to the next. Both sides use
// a valid/ready handshake. The block reports three results: the wide sum, the
// final carry, and the signed overflow of the full-width operation.
//
// Parameters
//   N        width of the adder slice in bits (N >= 2)
//   WORDS    number of slices per operation (WORDS >= 1)
//
// Ports
//   Clk        clock; all state changes on the rising edge
//   RstN       asynchronous reset, active low
//   InValid    request: InputA, InputB and Sub are valid
//   InReady    a request can be accepted (sequencer is idle)
//   InputA     operand A, W = N*WORDS bits
//   InputB     operand B, W bits
//   Sub        0 selects A+B, 1 selects A-B
//   OutValid   OutSum, CarryOut and OverFlow hold a completed result
//   OutReady   the consumer takes the result
//   OutSum     result, modulo 2^W
//   CarryOut   carry out of bit W-1 (for a subtract, 1 means no borrow)
//   OverFlow   signed overflow of the W-bit operation
// ----------------------------------------------------------------------------
module multiword_add_seq #(
   parameter int N     = 16,
   parameter int WORDS = 4
) (
   input  logic               Clk,
   input  logic               RstN,
   input  logic               InValid,
   output logic               InReady,
   input  logic [N*WORDS-1:0] InputA,
   input  logic [N*WORDS-1:0] InputB,
   input  logic               Sub,
   output logic               OutValid,
   input  logic               OutReady,
   output logic [N*WORDS-1:0] OutSum,
   output logic               CarryOut,
   output logic               OverFlow
);

   localparam int W    = N * WORDS;
   localparam int IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stateT;

   stateT            state;
   stateT            nextState;

   logic [W-1:0]     opA;
   logic [W-1:0]     opB;
   logic             carry;
   logic [IdxW-1:0]  idx;

   logic [N-1:0]     sliceA;
   logic [N-1:0]     sliceB;
   logic [N-1:0]     sliceSum;
   logic             sliceCarry;
   logic             lastSlice;
   logic             sliceOverflow;

   // The handshake outputs come straight from the state. This means a request
   // is only taken in IDLE and a result is only offered in DONE.
   assign InReady  = (state == IDLE);
   assign OutValid = (state == DONE);

   // State register. An asynchronous reset drops any operation in flight.
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. RUN lasts exactly WORDS cycles. DONE waits for the
   // consumer. OutReady has no effect in any other state.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: if (InValid) nextState = RUN;
         RUN:  if (lastSlice) nextState = DONE;
         DONE: if (OutReady) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // One slice of the shared adder. For a subtract, B was inverted when it was
   // captured and the carry was preset to 1. Because of that, this path is a
   // plain add in both modes. Overflow only matters on the top slice: it is
   // set when both operand sign bits differ from the sign bit of the result.
   always_comb begin
      sliceA                 = opA[idx*N +: N];
      sliceB                 = opB[idx*N +: N];
      {sliceCarry, sliceSum} = {1'b0, sliceA} + {1'b0, sliceB} + {{N{1'b0}}, carry};
      lastSlice              = (idx == IdxW'(WORDS - 1));
      sliceOverflow          = (opA[W-1] ^ sliceSum[N-1]) & (opB[W-1] ^ sliceSum[N-1]);
   end

   // Datapath registers. When a request is accepted, the operands are
   // captured, so the producer may change its inputs right away. Each RUN
   // cycle writes one slice of OutSum. The result registers hold their value
   // through IDLE until the next operation overwrites them. The slice index
   // goes back to zero after the last slice, so it never counts past WORDS-1.
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         opA      <= '0;
         opB      <= '0;
         carry    <= 1'b0;
         idx      <= '0;
         OutSum   <= '0;
         CarryOut <= 1'b0;
         OverFlow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (InValid) begin
                  opA   <= InputA;
                  opB   <= InputB ^ {W{Sub}};
                  carry <= Sub;
                  idx   <= '0;
               end
            end
            RUN: begin
               OutSum[idx*N +: N] <= sliceSum;
               carry              <= sliceCarry;
               if (lastSlice) begin
                  CarryOut <= sliceCarry;
                  OverFlow <= sliceOverflow;
                  idx      <= '0;
               end else begin
                  idx <= idx + IdxW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multiword_add_seq.sv
// ----------------------------------------------------------------------------
// tb_multiword_add_seq
//
// Directed testbench for multiword_add_seq with N=16, WORDS=4 (W=64).
// Inputs are driven on the falling edge and outputs are sampled on the falling
// edge, so every observation sits half a cycle away from the active edge.
// ----------------------------------------------------------------------------
module tb_multiword_add_seq;

   localparam int N     = 16;
   localparam int WORDS = 4;
   localparam int W     = N * WORDS;

   logic         Clk = 1'b0;
   logic         RstN;
   logic         InValid;
   logic         InReady;
   logic [W-1:0] InputA;
   logic [W-1:0] InputB;
   logic         Sub;
   logic         OutValid;
   logic         OutReady;
   logic [W-1:0] OutSum;
   logic         CarryOut;
   logic         OverFlow;

   int compared   = 0;
   int mismatched = 0;

   logic [W-1:0] heldSum;

   multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
      .Clk      (Clk),
      .RstN     (RstN),
      .InValid  (InValid),
      .InReady  (InReady),
      .InputA   (InputA),
      .InputB   (InputB),
      .Sub      (Sub),
      .OutValid (OutValid),
      .OutReady (OutReady),
      .OutSum   (OutSum),
      .CarryOut (CarryOut),
      .OverFlow (OverFlow)
   );

   // Free-running clock with a 10-time-unit period.
   always #5 Clk = ~Clk;

   // Hard stop in case something stalls the sequence below.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: count it, then report any mismatch with both values.
   task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                              input logic [W-1:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Runs one full operation and checks the results.
   // The request is held for exactly one accepting edge. The bench checks two
   // things about timing: the result is not yet valid after edge k+3, and it
   // is valid after edge k+4. After that the result is checked and drained.
   task automatic applyStimulus(input string tag, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic s,
                                input logic [W-1:0] expSum,
                                input logic expCarry, input logic expOvf);
      checkOutput({tag, ".inReadyIdle"}, W'(InReady), W'(1));
      InputA  = a;
      InputB  = b;
      Sub     = s;
      InValid = 1'b1;
      @(negedge Clk);
      InValid = 1'b0;
      InputA  = '1;
      InputB  = '1;
      Sub     = ~s;
      checkOutput({tag, ".inReadyBusy"}, W'(InReady), W'(0));
      repeat (WORDS - 1) @(negedge Clk);
      checkOutput({tag, ".notYetValid"}, W'(OutValid), W'(0));
      @(negedge Clk);
      checkOutput({tag, ".outValid"}, W'(OutValid), W'(1));
      checkOutput({tag, ".sum"},      OutSum,         expSum);
      checkOutput({tag, ".carry"},    W'(CarryOut),   W'(expCarry));
      checkOutput({tag, ".overflow"}, W'(OverFlow),   W'(expOvf));
      OutReady = 1'b1;
      @(negedge Clk);
      OutReady = 1'b0;
      checkOutput({tag, ".drained"}, W'(OutValid), W'(0));
   endtask

   // The directed sequence.
   initial begin
      RstN     = 1'b0;
      InValid  = 1'b0;
      OutReady = 1'b0;
      InputA   = '0;
      InputB   = '0;
      Sub      = 1'b0;
      repeat (2) @(negedge Clk);

      // Outputs while reset is held.
      checkOutput("reset.inReady",  W'(InReady),  W'(1));
      checkOutput("reset.outValid", W'(OutValid), W'(0));
      checkOutput("reset.sum",      OutSum,       64'h0);
      checkOutput("reset.carry",    W'(CarryOut), W'(0));
      checkOutput("reset.overflow", W'(OverFlow), W'(0));
      RstN = 1'b1;
      @(negedge Clk);

      // Asserting OutReady while idle must not produce a result.
      OutReady = 1'b1;
      @(negedge Clk);
      OutReady = 1'b0;
      checkOutput("idleOutReady.outValid", W'(OutValid), W'(0));

      applyStimulus("ripple",   64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
                    64'h0000_0000_0001_0000, 1'b0, 1'b0);
      applyStimulus("wrap",     64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                    64'h0, 1'b1, 1'b0);
      applyStimulus("sovf",     64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                    64'h8000_0000_0000_0000, 1'b0, 1'b1);
      applyStimulus("sub5m7",   64'h5, 64'h7, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
      applyStimulus("sub7m5",   64'h7, 64'h5, 1'b1,
                    64'h2, 1'b1, 1'b0);
      applyStimulus("mixed",    64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                    64'h2222_2222_2222_2211, 1'b0, 1'b0);
      applyStimulus("subNegOv", 64'h8000_0000_0000_0000, 64'h1, 1'b1,
                    64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

      // After an operation, the idle state must still hold the last result.
      checkOutput("idleHold.sum", OutSum, 64'h7FFF_FFFF_FFFF_FFFF);

      // Backpressure test. The consumer stalls in DONE for 10 cycles while a
      // new request is pending. The pending request must be ignored.
      InputA  = 64'h0000_0000_0000_0003;
      InputB  = 64'h0000_0000_0000_0004;
      Sub     = 1'b0;
      InValid = 1'b1;
      @(negedge Clk);
      InputA  = 64'hDEAD_BEEF_0000_0001;
      InputB  = 64'h0000_0000_1111_1111;
      repeat (WORDS) @(negedge Clk);
      checkOutput("bp.outValid0", W'(OutValid), W'(1));
      checkOutput("bp.sum0",      OutSum,       64'h7);
      heldSum = OutSum;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         checkOutput($sformatf("bp.outValid%0d", i + 1), W'(OutValid), W'(1));
         checkOutput($sformatf("bp.sum%0d", i + 1),      OutSum,       64'h7);
         checkOutput($sformatf("bp.inReady%0d", i + 1),  W'(InReady),  W'(0));
      end
      InValid  = 1'b0;
      OutReady = 1'b1;
      @(negedge Clk);
      OutReady = 1'b0;
      checkOutput("bp.releaseIdle", W'(InReady),  W'(1));
      checkOutput("bp.releaseOv",   W'(OutValid), W'(0));
      checkOutput("bp.releaseSum",  OutSum,       heldSum);

      // Reset during RUN. The reset is applied after two slices have been
      // written, and between clock edges, so it must act asynchronously.
      InputA  = 64'h0001_0002_0003_0004;
      InputB  = 64'h0010_0020_0030_0040;
      Sub     = 1'b0;
      InValid = 1'b1;
      @(negedge Clk);
      InValid = 1'b0;
      repeat (2) @(negedge Clk);
      checkOutput("midRun.partialSum", OutSum & 64'h0000_0000_FFFF_FFFF,
                  64'h0000_0000_0033_0044);
      #2;
      RstN = 1'b0;
      #1;
      checkOutput("midRst.outValid", W'(OutValid), W'(0));
      checkOutput("midRst.sum",      OutSum,       64'h0);
      checkOutput("midRst.inReady",  W'(InReady),  W'(1));
      checkOutput("midRst.carry",    W'(CarryOut), W'(0));
      @(negedge Clk);
      RstN = 1'b1;
      @(negedge Clk);
      checkOutput("postRst.outValid", W'(OutValid), W'(0));

      applyStimulus("afterRst", 64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b0,
                    64'h0011_0022_0033_0044, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
